// File: rtl/switchesqsys_mem_walker_pkg.sv
// -----------------------------------------------------------------------------
// switchesqsys_mem_walker_pkg
// Shared types and constants for the memory walker: FSM state encoding, job
// mode codes and the default geometry of the target on-chip RAM.
// -----------------------------------------------------------------------------
package switchesqsys_mem_walker_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 1024;

    localparam logic [1:0] MODE_FILL_CONST = 2'b00;
    localparam logic [1:0] MODE_FILL_INC   = 2'b01;
    localparam logic [1:0] MODE_CHECKSUM   = 2'b10;
    localparam logic [1:0] MODE_RSVD       = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_READ   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/switchesqsys_mem_walker.sv
// -----------------------------------------------------------------------------
// switchesqsys_mem_walker
// Walks a single-port on-chip RAM (read latency 1, no waitrequest) either
// filling a window of words with a constant / incrementing pattern, or reading
// the window back and summing it into a checksum.
//
// Ports
//   clk, reset     : sole clock, synchronous active-high reset
//   start          : begin a job (only looked at while idle)
//   mode           : 00 fill-const, 01 fill-inc, 10 checksum, 11 reserved
//   base_addr      : first word address (expected below DEPTH)
//   word_count     : words to process, values above DEPTH are clamped
//   fill_pattern   : fill value / seed for the incrementing fill
//   address, byteenable, chipselect, write, writedata, clken, readdata
//                  : RAM slave interface
//   busy           : job in progress
//   done           : one-cycle pulse when a job ends
//   err            : last job used the reserved mode
//   checksum       : result of the last checksum job
// -----------------------------------------------------------------------------
module switchesqsys_mem_walker
    import switchesqsys_mem_walker_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [DATA_W-1:0] fill_pattern,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic              clken,
    input  logic [DATA_W-1:0] readdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    localparam int CNT_W = ADDR_W + 1;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_remaining;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_checksum;
    logic              r_inc;
    logic              r_rd_valid;
    logic              r_err;
    logic              r_clken;

    logic              w_start;
    logic              w_access;
    logic              w_last;
    logic              w_no_access;
    logic [CNT_W-1:0]  w_count_clamped;
    logic [ADDR_W-1:0] w_addr_next;

    assign w_count_clamped = (word_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : word_count;
    assign w_start         = (r_state == ST_IDLE) && start;
    // Reserved mode and empty jobs skip straight to FINISH without touching RAM.
    assign w_no_access     = (mode == MODE_RSVD) || (w_count_clamped == '0);
    assign w_last          = (r_remaining == CNT_W'(1));
    assign w_addr_next     = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);

    // NOTE: reset is sampled on the clock edge, so it lives inside the
    // clocked block and sequential state is only ever written with <=.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal written here gets a default first so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_access     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        write        = 1'b0;
        writedata    = '0;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (w_no_access) begin
                        w_next_state = ST_FINISH;
                    end else if (mode == MODE_CHECKSUM) begin
                        w_next_state = ST_READ;
                    end else begin
                        w_next_state = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                w_access  = 1'b1;
                write     = 1'b1;
                writedata = r_wdata;
                if (w_last) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_READ: begin
                w_access = 1'b1;
                if (w_last) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_next_state = ST_FINISH;
            end
            ST_FINISH: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        chipselect = w_access;
        byteenable = w_access ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_wdata     <= '0;
            r_acc       <= '0;
            r_checksum  <= '0;
            r_inc       <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_err       <= 1'b0;
            r_clken     <= 1'b0;
        end else begin
            r_clken    <= 1'b1;
            // Read data returns one cycle after its address; the first READ
            // cycle therefore has nothing to accumulate yet.
            r_rd_valid <= (r_state == ST_READ);

            if (w_start) begin
                r_err <= (mode == MODE_RSVD);
                r_acc <= '0;
                // Address is left alone for jobs that never access RAM so
                // the bus keeps showing the last real access.
                if (!w_no_access) begin
                    r_addr      <= base_addr;
                    r_remaining <= w_count_clamped;
                    r_wdata     <= fill_pattern;
                    r_inc       <= (mode == MODE_FILL_INC);
                end
            end else if (w_access && !w_last) begin
                r_addr      <= w_addr_next;
                r_remaining <= r_remaining - CNT_W'(1);
                if (r_inc) begin
                    r_wdata <= r_wdata + DATA_W'(1);
                end
            end

            if ((r_state == ST_READ) && r_rd_valid) begin
                r_acc <= r_acc + readdata;
            end

            // DRAIN sees the last read word; fold it in as the result is stored.
            if (r_state == ST_DRAIN) begin
                r_checksum <= r_acc + readdata;
            end
        end
    end

    assign address  = r_addr;
    assign clken    = r_clken;
    assign err      = r_err;
    assign checksum = r_checksum;

endmodule

// File: tb/tb_switchesqsys_mem_walker.sv
// -----------------------------------------------------------------------------
// tb_switchesqsys_mem_walker
// Directed bench: the walker drives a behavioural 1024x32 RAM with a one-cycle
// registered read; each job's bus activity, timing and results are compared
// with hand-computed values.
// -----------------------------------------------------------------------------
module tb_switchesqsys_mem_walker;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic [31:0] fill_pattern;
    logic [9:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic        clken;
    logic [31:0] readdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    logic [31:0] mem [0:1023];

    int n_vec;
    int n_err;

    switchesqsys_mem_walker dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mode         (mode),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .fill_pattern (fill_pattern),
        .address      (address),
        .byteenable   (byteenable),
        .chipselect   (chipselect),
        .write        (write),
        .writedata    (writedata),
        .clken        (clken),
        .readdata     (readdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .checksum     (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM slave, read latency 1.
    always @(posedge clk) begin
        if (chipselect && clken) begin
            if (write) begin
                mem[address] <= writedata;
            end else begin
                readdata <= mem[address];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one cycle (cycle T); returns in cycle T+1.
    task automatic run_start(input logic [1:0] m, input logic [9:0] b,
                             input logic [10:0] c, input logic [31:0] p);
        mode         = m;
        base_addr    = b;
        word_count   = c;
        fill_pattern = p;
        start        = 1'b1;
        step();
        start        = 1'b0;
    endtask

    task automatic check_access(input string tag, input logic [9:0] a,
                                input logic wr, input logic [31:0] d);
        check({tag, " cs"},    chipselect, 1'b1);
        check({tag, " be"},    byteenable, 4'hF);
        check({tag, " addr"},  address,    a);
        check({tag, " write"}, write,      wr);
        check({tag, " wdata"}, writedata,  d);
        check({tag, " done"},  done,       1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " addr"},     address,    '0);
        check({tag, " be"},       byteenable, '0);
        check({tag, " cs"},       chipselect, 1'b0);
        check({tag, " write"},    write,      1'b0);
        check({tag, " wdata"},    writedata,  '0);
        check({tag, " clken"},    clken,      1'b0);
        check({tag, " busy"},     busy,       1'b0);
        check({tag, " done"},     done,       1'b0);
        check({tag, " err"},      err,        1'b0);
        check({tag, " checksum"}, checksum,   '0);
    endtask

    logic [9:0]  inc_addr [4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    logic [31:0] inc_data [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};

    initial begin
        int n_acc;
        int n_done;
        int n_cyc;

        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b1;
        start        = 1'b0;
        mode         = 2'b00;
        base_addr    = '0;
        word_count   = '0;
        fill_pattern = '0;
        readdata     = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0BAD_0000 + i;

        // Reset state.
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
        check("post-reset clken", clken, 1'b1);
        check("post-reset busy",  busy,  1'b0);

        // Fill-constant, base 0, four words.
        run_start(2'b00, 10'd0, 11'd4, 32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) begin
            check("fillc busy", busy, 1'b1);
            check_access($sformatf("fillc k%0d", k), 10'(k), 1'b1, 32'hDEAD_BEEF);
            step();
        end
        check("fillc done T+5", done,       1'b1);
        check("fillc cs T+5",   chipselect, 1'b0);
        check("fillc addr hold", address,   10'd3);
        step();
        check("fillc done once", done, 1'b0);
        check("fillc idle",      busy, 1'b0);
        for (int k = 0; k < 4; k++) check($sformatf("fillc ram%0d", k), mem[k], 32'hDEAD_BEEF);

        // Fill-increment wrapping over the top of memory and of the data width.
        run_start(2'b01, 10'd1022, 11'd4, 32'hFFFF_FFFE);
        for (int k = 0; k < 4; k++) begin
            check_access($sformatf("filli k%0d", k), inc_addr[k], 1'b1, inc_data[k]);
            step();
        end
        check("filli done", done, 1'b1);
        step();
        check("filli ram1023", mem[1023], 32'hFFFF_FFFF);
        check("filli ram1",    mem[1],    32'h1);

        // Checksum over three words, carry wraps: 1 + 2 + FFFFFFFF = 2.
        mem[10] = 32'h1;
        mem[11] = 32'h2;
        mem[12] = 32'hFFFF_FFFF;
        run_start(2'b10, 10'd10, 11'd3, 32'h1234_5678);
        for (int k = 0; k < 3; k++) begin
            check_access($sformatf("csum k%0d", k), 10'(10 + k), 1'b0, 32'h0);
            step();
        end
        check("csum drain cs",   chipselect, 1'b0);
        check("csum drain busy", busy,       1'b1);
        check("csum drain done", done,       1'b0);
        step();
        check("csum done T+5", done,     1'b1);
        check("csum value",    checksum, 32'h0000_0002);
        step();

        // Reserved mode: immediate finish, no access, err set and held.
        run_start(2'b11, 10'd50, 11'd8, 32'h0);
        check("rsvd done T+1", done,       1'b1);
        check("rsvd cs",       chipselect, 1'b0);
        check("rsvd err",      err,        1'b1);
        step();
        check("rsvd err held", err,        1'b1);
        check("rsvd idle",     busy,       1'b0);

        // Zero count: immediate finish, no access, err cleared by the start.
        run_start(2'b00, 10'd7, 11'd0, 32'hAAAA_AAAA);
        check("zero done T+1", done,       1'b1);
        check("zero cs",       chipselect, 1'b0);
        check("zero err",      err,        1'b0);
        check("zero addr held", address,   10'd12);
        step();

        // Clamp: 2047 words -> 1024 accesses; a start mid-job is ignored.
        n_acc  = 0;
        n_done = 0;
        n_cyc  = 0;
        run_start(2'b00, 10'd5, 11'd2047, 32'h0000_5A5A);
        while (busy && n_cyc < 1100) begin
            if (chipselect) n_acc++;
            if (done) n_done++;
            if (n_cyc == 100) begin
                mode       = 2'b11;
                word_count = 11'd0;
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            n_cyc++;
        end
        start = 1'b0;
        check("clamp finished",  busy,     1'b0);
        check("clamp accesses",  n_acc,    1024);
        check("clamp done once", n_done,   1);
        check("clamp err",       err,      1'b0);
        check("clamp last addr", address,  10'd4);
        check("clamp csum held", checksum, 32'h0000_0002);
        check("clamp ram4",      mem[4],   32'h0000_5A5A);

        // Reset on the third access of a 16-word fill.
        run_start(2'b01, 10'd100, 11'd16, 32'h0);
        step();
        step();
        check_access("rst 3rd", 10'd102, 1'b1, 32'h2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("rst abort");
        // First cycle after reset: a new start must be accepted.
        run_start(2'b00, 10'd200, 11'd2, 32'h0000_0055);
        check_access("rst new k0", 10'd200, 1'b1, 32'h55);
        step();
        check_access("rst new k1", 10'd201, 1'b1, 32'h55);
        step();
        check("rst new done", done, 1'b1);
        step();
        check("rst new idle", busy, 1'b0);
        check("rst ram201",   mem[201], 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/switchesqsys_mem_walker.md
SWITCHESQSYS_MEM_WALKER -- requirements
Module: switchesqsys_mem_walker

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the target memory.
REQ-002 SHALL have parameter DATA_W, default 32, data width of the target memory.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words in the target memory.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have these ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- mode  in  2  job type: 00 fill-constant, 01 fill-increment, 10 checksum, 11 reserved.
- base_addr  in  ADDR_W  first word address.
- word_count  in  ADDR_W+1  words to process, range 0..DEPTH.
- fill_pattern  in  DATA_W  fill value, or seed value for fill-increment.
- address  out  ADDR_W  memory word address.
- byteenable  out  4  memory byte lanes.
- chipselect  out  1  memory access strobe.
- write  out  1  1 = write, 0 = read.
- writedata  out  DATA_W  memory write data.
- clken  out  1  memory clock enable.
- readdata  in  DATA_W  memory read data, valid one cycle after a read address.
- busy  out  1  a job is in progress.
- done  out  1  one-cycle pulse at job end.
- err  out  1  the last job used mode 11; held until the next start.
- checksum  out  DATA_W  result of the last checksum job.

Function
REQ-006 States SHALL be IDLE, FILL, READ, DRAIN and FINISH.
REQ-007 In IDLE with start=1, the block SHALL latch mode, base_addr, word_count and fill_pattern, clear err, and go to FILL for modes 00/01 or READ for mode 10.
REQ-008 A start with word_count=0, or with mode=11, SHALL go directly to FINISH with no memory access; mode 11 SHALL set err=1.
REQ-009 A word_count greater than DEPTH SHALL be clamped to DEPTH.
REQ-010 In FILL and READ, the block SHALL issue exactly one access per cycle, with chipselect=1, byteenable=4'hF and clken=1.
REQ-011 If start is sampled at cycle T, accesses SHALL occur on cycles T+1..T+N, where N is the clamped word count.
REQ-012 Access k (k = 0..N-1) SHALL use address (base_addr+k) mod DEPTH, wrapping from DEPTH-1 to 0.
REQ-013 FILL SHALL drive write=1, with writedata = fill_pattern (mode 00) or fill_pattern+k mod 2^DATA_W (mode 01).
REQ-014 After FILL, the block SHALL enter FINISH at T+N+1.
REQ-015 READ SHALL drive write=0 and writedata=0.
REQ-016 In a checksum job, the block SHALL zero the accumulator at start, and in cycles T+2..T+N+1 SHALL add readdata to it mod 2^DATA_W.
REQ-017 READ SHALL go to DRAIN after its last access; DRAIN (one cycle, no access) SHALL capture the final word and then go to FINISH.
REQ-018 checksum SHALL update on entry to FINISH and hold until the next checksum job finishes.
REQ-019 FINISH SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-020 busy SHALL be 1 in FILL, READ, DRAIN and FINISH, and 0 in IDLE.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 Outside FILL/READ, chipselect and write SHALL be 0; address SHALL hold its last value.
REQ-023 clken SHALL be 1 at all times except during reset.

Reset
REQ-024 During reset, the state SHALL be IDLE.
REQ-025 During reset, these outputs SHALL be 0: address, byteenable, chipselect, write, writedata, clken, busy, done, err, checksum.
REQ-026 A reset mid-job SHALL abort the job; no access SHALL be issued in the cycle after reset is sampled, and no done pulse SHALL follow.
REQ-027 After reset deasserts, start SHALL be honoured on the first cycle.

Structure
REQ-028 Package switchesqsys_mem_walker_pkg SHALL hold the state enum, the mode codes (MODE_FILL_CONST, MODE_FILL_INC, MODE_CHECKSUM, MODE_RSVD), and default ADDR_W/DATA_W/DEPTH constants.
REQ-029 The block SHALL be a single module with no sub-module; the address counter, word counter and accumulator SHALL be inline.
REQ-030 The memory-side ports SHALL connect directly to a single-port on-chip RAM slave with fixed read latency 1 and no waitrequest.

Verification
REQ-031 Fill-constant: mode=00, base=0, count=4, pattern=32'hDEADBEEF -> writes to 0..3 on cycles T+1..T+4; done at T+5; RAM words 0..3 = DEADBEEF.
REQ-032 Fill-increment with wrap: mode=01, base=1022, count=4, pattern=32'hFFFFFFFE -> addresses 1022, 1023, 0, 1 with data FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-033 Checksum: RAM[10..12] = 1, 2, 32'hFFFFFFFF; mode=10, base=10, count=3 -> reads T+1..T+3; done at T+5; checksum = 32'h00000002.
REQ-034 Zero count and reserved mode: count=0 -> done at T+1, chipselect never high, err=0; mode=11, count=8 -> done at T+1, no access, err=1.
REQ-035 Clamp and busy: count=2047 -> exactly 1024 accesses; start pulsed mid-job -> ignored, done pulses once.
REQ-036 Reset mid-job: reset on the 3rd access of a count=16 fill -> next cycle all outputs 0 and no done; a new start after reset completes normally.
